// File: rtl/div_issue_if.sv
// Handshake bundle between the EX-stage divide issue controller, the pipeline and the divider.
// master = the issue controller; slave = pipeline/divider side.
interface div_issue_if;
    localparam int unsigned XLEN = 32;

    logic              div_req_i;
    logic              div_signed_i;
    logic [XLEN-1:0]   op1_i;
    logic [XLEN-1:0]   op2_i;
    logic              flush_i;
    logic              stall_i;
    logic              div_ready_i;
    logic [2*XLEN-1:0] div_result_i;

    logic              div_start_o;
    logic              div_annul_o;
    logic              div_signed_o;
    logic [XLEN-1:0]   div_op1_o;
    logic [XLEN-1:0]   div_op2_o;
    logic              stall_req_o;
    logic              hilo_we_o;
    logic [XLEN-1:0]   hi_o;
    logic [XLEN-1:0]   lo_o;
    logic              timeout_o;

    modport master (
        input  div_req_i, div_signed_i, op1_i, op2_i, flush_i, stall_i,
               div_ready_i, div_result_i,
        output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
               stall_req_o, hilo_we_o, hi_o, lo_o, timeout_o
    );

    modport slave (
        output div_req_i, div_signed_i, op1_i, op2_i, flush_i, stall_i,
               div_ready_i, div_result_i,
        input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
               stall_req_o, hilo_we_o, hi_o, lo_o, timeout_o
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: issues once, stalls EX until the
// result returns, writes HI/LO exactly once, and handles flush, downstream stall and timeout.
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT    = 48,
    parameter int unsigned CANCEL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    div_issue_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             start_q, start_nxt;
    logic             annul_q, annul_nxt;
    logic             we_q, we_nxt;
    logic             timeout_q, timeout_nxt;
    logic             signed_q;
    logic [XLEN-1:0]  op1_q, op2_q, hi_q, lo_q;
    logic             latch_ops, latch_res;
    logic             stall_req_c;

    // Saturating increment of the shared BUSY/CANCEL cycle counter
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // State register plus the registered outputs and operand/result holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            signed_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            start_q   <= start_nxt;
            annul_q   <= annul_nxt;
            we_q      <= we_nxt;
            timeout_q <= timeout_nxt;
            if (latch_ops) begin
                signed_q <= bus.div_signed_i;
                op1_q    <= bus.op1_i;
                op2_q    <= bus.op2_i;
            end
            if (latch_res) begin
                hi_q <= bus.div_result_i[2*XLEN-1:XLEN];
                lo_q <= bus.div_result_i[XLEN-1:0];
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        start_nxt   = 1'b0;
        annul_nxt   = 1'b0;
        we_nxt      = 1'b0;
        timeout_nxt = timeout_q;
        latch_ops   = 1'b0;
        latch_res   = 1'b0;
        stall_req_c = 1'b0;

        unique case (state)
            IDLE: begin
                stall_req_c = bus.div_req_i & ~bus.flush_i;
                if (bus.div_req_i && !bus.flush_i) begin
                    latch_ops = 1'b1;
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_req_c = 1'b1;
                start_nxt   = 1'b1;
                cnt_nxt     = cnt_inc;
                // Flush beats a same-cycle ready so a killed instruction never writes back
                if (bus.flush_i) begin
                    annul_nxt = 1'b1;
                    start_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = CANCEL;
                end else if (bus.div_ready_i) begin
                    latch_res = 1'b1;
                    we_nxt    = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (32'(cnt_inc) >= TIMEOUT) begin
                    timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                // Holding here while EX is stalled keeps the same instruction from reissuing
                if (!bus.stall_i || bus.flush_i) begin
                    state_nxt = IDLE;
                end
            end
            CANCEL: begin
                stall_req_c = bus.div_req_i;
                cnt_nxt     = cnt_inc;
                if (32'(cnt) + 32'd1 >= CANCEL_CYC) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.div_start_o  = start_q;
    assign bus.div_annul_o  = annul_q;
    assign bus.div_signed_o = signed_q;
    assign bus.div_op1_o    = op1_q;
    assign bus.div_op2_o    = op2_q;
    assign bus.stall_req_o  = stall_req_c;
    assign bus.hilo_we_o    = we_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: an EX-stage driver issues divides, a divider model
// answers, and a negedge monitor checks every HI/LO write against queued expectations.
module tb_div_issue_ctrl;
    localparam int unsigned TIMEOUT    = 48;
    localparam int unsigned CANCEL_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_issue_if bus ();

    div_issue_ctrl #(.TIMEOUT(TIMEOUT), .CANCEL_CYC(CANCEL_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          exp_annul  = 0;
    int          seen_annul = 0;
    int          div_lat    = 36;
    bit          hang       = 1'b0;
    int          dcnt;

    // Architectural DIV/DIVU: {remainder, quotient}, divide-by-zero gives zero
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        if (b == 32'd0) return 64'd0;
        sa = a;
        sb = b;
        if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider model: ready after a latency while start is held, result from latched operands
    always @(posedge clk or posedge rst) begin
        if (rst || !bus.div_start_o) begin
            dcnt             <= 0;
            bus.div_ready_i  <= 1'b0;
            bus.div_result_i <= 64'd0;
        end else begin
            dcnt <= dcnt + 1;
            if (!hang && (dcnt + 1 >= ((bus.div_op2_o == 32'd0) ? 2 : div_lat))) begin
                bus.div_ready_i  <= 1'b1;
                bus.div_result_i <= ref_div(bus.div_op1_o, bus.div_op2_o, bus.div_signed_o);
            end
        end
    end

    // Monitor: write scoreboard, annul pulse width, post-annul start gap, stall while busy
    bit          annul_prev   = 1'b0;
    bit          annul_recent = 1'b0;
    bit          start_prev   = 1'b0;
    int unsigned low_run      = 0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            annul_prev   = 1'b0;
            annul_recent = 1'b0;
            start_prev   = 1'b0;
            low_run      = 0;
        end else begin
            if (bus.hilo_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_hilo_write", 64'(bus.hilo_we_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hilo_result", {bus.hi_o, bus.lo_o}, e);
                end
            end
            if (bus.div_annul_o) begin
                seen_annul++;
                if (annul_prev) chk("annul_width", 64'd2, 64'd1);
                annul_recent = 1'b1;
                low_run      = 0;
            end else if (!bus.div_start_o) begin
                low_run++;
            end
            if (bus.div_start_o) begin
                chk("stall_while_busy", 64'(bus.stall_req_o), 64'd1);
                if (!start_prev && annul_recent) begin
                    chk("cancel_gap", 64'(low_run >= CANCEL_CYC), 64'd1);
                    annul_recent = 1'b0;
                end
            end
            annul_prev = bus.div_annul_o;
            start_prev = bus.div_start_o;
        end
    end

    // Present one instruction in EX until it advances (or is killed by a non-refetched flush)
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int flush_at, input bit refetch,
                           input int stall_n);
        bit done    = 1'b0;
        bit flushed = 1'b0;
        bit leave;
        int stall_left = 0;
        exp_q.push_back(exp);
        bus.div_req_i    = 1'b1;
        bus.op1_i        = a;
        bus.op2_i        = b;
        bus.div_signed_i = s;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            bus.flush_i = 1'b0;
            if (flush_at >= 0 && !flushed && cyc >= flush_at && bus.div_start_o) begin
                bus.flush_i = 1'b1;
                flushed     = 1'b1;
                exp_annul++;
                if (!refetch) void'(exp_q.pop_back());
            end
            if (bus.hilo_we_o) stall_left = stall_n;
            bus.stall_i = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            #1;
            leave = bus.flush_i ? !refetch : (!bus.stall_req_o && !bus.stall_i);
            @(posedge clk);
            #1;
            done = leave;
        end
        bus.div_req_i = 1'b0;
        bus.flush_i   = 1'b0;
        bus.stall_i   = 1'b0;
        chk("instr_advanced", 64'(done), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_start"},   64'(bus.div_start_o),  64'd0);
        chk({tag, "_annul"},   64'(bus.div_annul_o),  64'd0);
        chk({tag, "_signed"},  64'(bus.div_signed_o), 64'd0);
        chk({tag, "_op1"},     64'(bus.div_op1_o),    64'd0);
        chk({tag, "_op2"},     64'(bus.div_op2_o),    64'd0);
        chk({tag, "_stallreq"},64'(bus.stall_req_o),  64'd0);
        chk({tag, "_we"},      64'(bus.hilo_we_o),    64'd0);
        chk({tag, "_hi"},      64'(bus.hi_o),         64'd0);
        chk({tag, "_lo"},      64'(bus.lo_o),         64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout_o),    64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          fa;
        bus.div_req_i    = 1'b0;
        bus.div_signed_i = 1'b0;
        bus.op1_i        = 32'd0;
        bus.op2_i        = 32'd0;
        bus.flush_i      = 1'b0;
        bus.stall_i      = 1'b0;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        div_lat = 36;
        run_div(32'd7, 32'd2, 1'b1, {32'h00000001, 32'h00000003}, -1, 1'b0, 0);
        div_lat = 10;
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, 1'b0, 0);
        run_div(32'hFFFFFFF9, 32'd2, 1'b0, {32'h00000001, 32'h7FFFFFFC}, -1, 1'b0, 0);
        run_div(32'd12345, 32'd0, 1'b1, 64'd0, -1, 1'b0, 0);
        div_lat = 36;
        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 10, 1'b1, 0);
        div_lat = 8;
        run_div(32'd12345, 32'd77, 1'b0, {32'd25, 32'd160}, -1, 1'b0, 5);

        // Randomized traffic with flushes, refetches and downstream stalls
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0)      b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else                                b = 32'($urandom_range(1, 1000));
            s = 1'($urandom_range(0, 1));
            if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            div_lat = int'($urandom_range(1, 40));
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 42)) : -1;
            run_div(a, b, s, ref_div(a, b, s), fa, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Hung divider: sticky timeout, then asynchronous reset mid-BUSY
        repeat (4) @(posedge clk);
        #1;
        hang             = 1'b1;
        bus.div_req_i    = 1'b1;
        bus.op1_i        = 32'd99;
        bus.op2_i        = 32'd3;
        bus.div_signed_i = 1'b1;
        @(posedge clk);
        #1;
        chk("hang_started", 64'(bus.div_start_o), 64'd1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("timeout_not_yet", 64'(bus.timeout_o), 64'd0);
        @(posedge clk);
        #1;
        chk("timeout_set", 64'(bus.timeout_o), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("timeout_sticky", 64'(bus.timeout_o), 64'd1);
        chk("still_busy", 64'(bus.div_start_o), 64'd1);
        #2;
        rst           = 1'b1;
        bus.div_req_i = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        hang = 1'b0;
        div_lat = 5;
        run_div(32'd7, 32'd2, 1'b1, {32'h00000001, 32'h00000003}, -1, 1'b0, 0);
        chk("timeout_cleared", 64'(bus.timeout_o), 64'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("annul_count", 64'(seen_annul), 64'(exp_annul));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
